// File: rtl/fifo_demo_pkg.sv
// Shared types and constants for the dual-clock demo FIFO (write-side filler and read-side checker).
package fifo_demo_pkg;

    localparam int unsigned DEF_DW     = 8;
    localparam int unsigned FIFO_DEPTH = 256;
    localparam int unsigned ERR_W      = 8;
    localparam int unsigned ERR_MAX    = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Increment that sticks at ERR_MAX instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_W'(ERR_MAX)) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/rd_fifo_chk_if.sv
// Read-port handshake between the demo FIFO and its read-side controller.
interface rd_fifo_chk_if #(
    parameter int unsigned DW = fifo_demo_pkg::DEF_DW
) ();

    logic          rdfull;
    logic          rdempty;
    logic          rdreq;
    logic [DW-1:0] q;

    modport master (input rdfull, input rdempty, input q, output rdreq);
    modport slave  (output rdfull, output rdempty, output q, input rdreq);

endinterface

// File: rtl/rd_fifo_chk_seq_checker.sv
// Compares each valid word against an incrementing sequence and keeps a saturating error count.
module seq_checker
    import fifo_demo_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [DW-1:0]    data,
    output logic [ERR_W-1:0] err_cnt
);

    logic [DW-1:0] expected;

    // Expected value always advances so one bad word costs exactly one error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= '0;
            err_cnt  <= '0;
        end else if (clear) begin
            expected <= '0;
        end else if (valid) begin
            expected <= expected + DW'(1);
            if (data != expected) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: rtl/rd_fifo_chk.sv
// Read-side FIFO controller: waits for full, drains in one burst, checks the 0,1,2,... pattern.
module rd_fifo_chk
    import fifo_demo_pkg::*;
#(
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    rd_fifo_chk_if.master      fifo,
    output logic [DW-1:0]      rd_data,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               burst_done,
    output logic               led_rd
);

    localparam int unsigned DRAIN_W = 2;

    state_t             state_q;
    state_t             state_d;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               rdreq_c;
    logic               q_valid_c;
    logic               start_c;
    logic               drain_last_c;

    // Read request is combinational so nothing is issued in the cycle the FIFO reports empty.
    assign rdreq_c      = (state_q == READ) && !fifo.rdempty;
    assign fifo.rdreq   = rdreq_c;
    assign drain_last_c = (drain_cnt == DRAIN_W'(RD_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo.rdfull && !fifo.rdempty) begin
                    state_d = READ;
                    start_c = 1'b1;
                end
            end
            READ: begin
                if (fifo.rdempty) begin
                    state_d = (RD_LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tracks outstanding reads; its output marks the cycle q holds a requested word.
    generate
        if (RD_LAT == 0) begin : g_show_ahead
            assign q_valid_c = rdreq_c;
        end else begin : g_lat_pipe
            logic [RD_LAT-1:0] pipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe <= '0;
                end else begin
                    pipe <= RD_LAT'({pipe, rdreq_c});
                end
            end
            assign q_valid_c = pipe[RD_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt  <= '0;
            rd_cnt     <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            burst_done <= 1'b0;
            led_rd     <= 1'b0;
        end else begin
            drain_cnt  <= (state_q == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
            burst_done <= (state_d == DONE);
            led_rd     <= (state_d == READ) || (state_d == DRAIN);
            rd_valid   <= q_valid_c;
            if (q_valid_c) begin
                rd_data <= fifo.q;
            end
            if (start_c) begin
                rd_cnt <= '0;
            end else if (rdreq_c && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
        end
    end

    seq_checker #(.DW(DW)) u_seq_checker (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_c),
        .valid   (q_valid_c),
        .data    (fifo.q),
        .err_cnt (err_cnt)
    );

endmodule

// File: tb/tb_rd_fifo_chk.sv
// Bench: two controllers (normal-mode RD_LAT=1, show-ahead RD_LAT=0) each behind a depth-256 FIFO model.
module tb_rd_fifo_chk;
    import fifo_demo_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = 9;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic             wr_en      [2];
    logic [DW-1:0]    wr_data    [2];
    logic             force_full [2];
    logic             flush      [2];

    logic             rdreq_o      [2];
    logic             rdempty_o    [2];
    logic [DW-1:0]    rd_data_o    [2];
    logic             rd_valid_o   [2];
    logic [CNT_W-1:0] rd_cnt_o     [2];
    logic [7:0]       err_cnt_o    [2];
    logic             burst_done_o [2];
    logic             led_rd_o     [2];

    int vectors = 0;
    int miscompares = 0;
    int tally [2];
    logic [DW-1:0] load_q [$];

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int unsigned LAT = (g == 0) ? 1 : 0;
        rd_fifo_chk_if #(.DW(DW)) bus ();

        logic [DW-1:0] mem [DEPTH];
        logic [7:0]    wp, rp;
        logic [DW-1:0] q_reg;
        logic [8:0]    cnt;

        assign bus.rdempty = (cnt == 9'd0);
        assign bus.rdfull  = (cnt == 9'(DEPTH)) || force_full[g];
        assign bus.q       = (LAT == 0) ? mem[rp] : q_reg;
        assign rdreq_o[g]   = bus.rdreq;
        assign rdempty_o[g] = bus.rdempty;

        // FIFO model: normal mode registers q on rdreq, show-ahead presents the head word.
        always @(posedge clk) begin
            if (flush[g]) begin
                cnt <= 9'd0;
                wp  <= 8'd0;
                rp  <= 8'd0;
            end else begin
                if (wr_en[g]) begin
                    mem[wp] <= wr_data[g];
                    wp      <= wp + 8'd1;
                end
                if (bus.rdreq) begin
                    q_reg <= mem[rp];
                    rp    <= rp + 8'd1;
                end
                cnt <= cnt + 9'(wr_en[g]) - 9'(bus.rdreq);
            end
        end

        rd_fifo_chk #(.DW(DW), .RD_LAT(LAT), .CNT_W(CNT_W)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .fifo       (bus),
            .rd_data    (rd_data_o[g]),
            .rd_valid   (rd_valid_o[g]),
            .rd_cnt     (rd_cnt_o[g]),
            .err_cnt    (err_cnt_o[g]),
            .burst_done (burst_done_o[g]),
            .led_rd     (led_rd_o[g])
        );
    end

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [28:0] outs(input int k);
        return {rdreq_o[k], rd_valid_o[k], burst_done_o[k], led_rd_o[k],
                rd_data_o[k], rd_cnt_o[k], err_cnt_o[k]};
    endfunction

    task automatic flush_fifo(input int k);
        @(negedge clk);
        flush[k] = 1'b1;
        @(negedge clk);
        flush[k] = 1'b0;
    endtask

    // mode 0 clean, 1 word 100 = 0xAA, 2 random corruption, 3 every word inverted
    task automatic fill(input int k, input int mode);
        int n_req = 0;
        logic [DW-1:0] w;
        load_q.delete();
        for (int i = 0; i < int'(DEPTH); i++) begin
            w = 8'(i);
            case (mode)
                1: if (i == 100) w = 8'hAA;
                2: if ($urandom_range(0, 7) == 0) w = 8'($urandom);
                3: w = ~8'(i);
                default: ;
            endcase
            load_q.push_back(w);
            if (w != 8'(i)) tally[k]++;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            if (rdreq_o[k]) n_req++;
            wr_en[k]   = 1'b1;
            wr_data[k] = load_q[i];
        end
        @(negedge clk);
        if (rdreq_o[k]) n_req++;
        wr_en[k] = 1'b0;
        vectors++;
        if (n_req != 0) begin
            miscompares++;
            $display("FAIL fill_no_read k=%0d rdreq_cycles=%0d expected=0", k, n_req);
        end
    endtask

    task automatic run_burst(input int k);
        logic [DW-1:0] exp_q [$];
        int req_cyc [$];
        int cyc = 0, n_req = 0, n_done = 0, empty_cyc = -1, post = 0, r;
        int lat = (k == 0) ? 1 : 0;
        bit first = 1'b1;
        logic [DW-1:0] e;
        exp_q = load_q;
        while (cyc < 1200 && !(n_done > 0 && post >= 4)) begin
            @(negedge clk);
            cyc++;
            if (n_done > 0) post++;
            if (rdreq_o[k]) begin
                if (first) begin
                    first = 1'b0;
                    vectors++;
                    if (rd_cnt_o[k] !== '0 || led_rd_o[k] !== 1'b1) begin
                        miscompares++;
                        $display("FAIL burst_start k=%0d rd_cnt=%0d led_rd=%b expected 0/1",
                                 k, rd_cnt_o[k], led_rd_o[k]);
                    end
                end
                n_req++;
                req_cyc.push_back(cyc);
            end
            if (n_req > 0 && empty_cyc < 0 && rdempty_o[k]) empty_cyc = cyc;
            if (rd_valid_o[k]) begin
                vectors++;
                if (req_cyc.size() == 0 || exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_valid k=%0d cyc=%0d data=%h expected no strobe",
                             k, cyc, rd_data_o[k]);
                end else begin
                    r = req_cyc.pop_front();
                    e = exp_q.pop_front();
                    if (cyc != r + lat + 1 || rd_data_o[k] !== e) begin
                        miscompares++;
                        $display("FAIL rd_data k=%0d cyc=%0d got=%h@%0d expected=%h@%0d",
                                 k, cyc, rd_data_o[k], cyc, e, r + lat + 1);
                    end
                end
            end
            if (burst_done_o[k]) begin
                n_done++;
                vectors++;
                if (cyc != empty_cyc + lat + 1 || led_rd_o[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL burst_done_time k=%0d cyc=%0d led_rd=%b expected cyc=%0d led_rd=0",
                             k, cyc, led_rd_o[k], empty_cyc + lat + 1);
                end
            end
        end
        vectors++;
        if (n_req != load_q.size() || exp_q.size() != 0 || n_done != 1) begin
            miscompares++;
            $display("FAIL burst_counts k=%0d reqs=%0d left=%0d dones=%0d expected %0d/0/1",
                     k, n_req, exp_q.size(), n_done, load_q.size());
        end
        vectors++;
        if (rd_cnt_o[k] !== CNT_W'(load_q.size())) begin
            miscompares++;
            $display("FAIL rd_cnt k=%0d got=%0d expected=%0d", k, rd_cnt_o[k], load_q.size());
        end
        vectors++;
        if (err_cnt_o[k] !== 8'(sat(tally[k]))) begin
            miscompares++;
            $display("FAIL err_cnt k=%0d got=%0d expected=%0d", k, err_cnt_o[k], sat(tally[k]));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (outs(k) !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs k=%0d got=%h expected=0", k, outs(k));
            end
            flush[k] = 1'b0;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_burst();
        fill(0, 0);
        run_burst(0);
    endtask

    task automatic test_corrupt_word();
        fill(0, 1);
        run_burst(0);
    endtask

    task automatic test_show_ahead();
        fill(1, 0);
        run_burst(1);
    endtask

    task automatic test_random_bursts();
        for (int n = 0; n < 4; n++) begin
            fill(n % 2, 2);
            run_burst(n % 2);
        end
    endtask

    task automatic test_idle_hold();
        int busy = 0;
        flush_fifo(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr_en[0]   = 1'b1;
            wr_data[0] = 8'(i);
        end
        @(negedge clk);
        wr_en[0] = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rdreq_o[0] || led_rd_o[0] || burst_done_o[0]) busy++;
        end
        vectors++;
        if (busy != 0) begin
            miscompares++;
            $display("FAIL partial_fill_idle busy_cycles=%0d expected=0", busy);
        end
        flush_fifo(0);
        force_full[0] = 1'b1;
        busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (rdreq_o[0] || led_rd_o[0] || burst_done_o[0]) busy++;
        end
        force_full[0] = 1'b0;
        vectors++;
        if (busy != 0) begin
            miscompares++;
            $display("FAIL full_and_empty_idle busy_cycles=%0d expected=0", busy);
        end
    endtask

    task automatic test_saturate();
        fill(0, 3);
        run_burst(0);
        fill(0, 3);
        run_burst(0);
        fill(0, 3);
        run_burst(0);
    endtask

    task automatic test_reset_midburst();
        int n = 0, guard = 0, busy = 0;
        fill(0, 0);
        while (n < 50 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (rdreq_o[0]) n++;
        end
        vectors++;
        if (n != 50) begin
            miscompares++;
            $display("FAIL midburst_reads got=%0d expected=50", n);
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (outs(k) !== '0) begin
                miscompares++;
                $display("FAIL midburst_reset k=%0d got=%h expected=0", k, outs(k));
            end
            tally[k] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rdreq_o[0] || led_rd_o[0] || burst_done_o[0]) busy++;
        end
        vectors++;
        if (busy != 0) begin
            miscompares++;
            $display("FAIL post_reset_idle busy_cycles=%0d expected=0", busy);
        end
        flush_fifo(0);
        fill(0, 0);
        run_burst(0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_en[k]      = 1'b0;
            wr_data[k]    = '0;
            force_full[k] = 1'b0;
            flush[k]      = 1'b1;
            tally[k]      = 0;
        end
        test_reset();
        test_clean_burst();
        test_corrupt_word();
        test_show_ahead();
        test_random_bursts();
        test_idle_hold();
        test_saturate();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
